// File: rtl/univ_shift_reg.sv
// Universal WIDTH-bit register: hold, load, shifts, rotates, sync clear and serial I/O.
// A saturating shift counter with a one-edge done pulse supports SerDes use.
module univ_shift_reg #(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                       clk,
  input  logic                       clr_n,
  input  logic                       en,
  input  logic [2:0]                 mode,
  input  logic [WIDTH-1:0]           d,
  input  logic                       sin,
  output logic [WIDTH-1:0]           q,
  output logic                       sout,
  output logic [$clog2(WIDTH+1)-1:0] cnt,
  output logic                       done
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_CLR  = 3'b110,
    MODE_ASR  = 3'b111
  } mode_e;

  logic [WIDTH-1:0] reg_q, reg_d;
  logic             sout_q, sout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             is_shift;

  always_comb begin
    reg_d    = reg_q;
    sout_d   = sout_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    is_shift = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_HOLD: ;
        MODE_LOAD: begin
          reg_d = d;
          cnt_d = '0;
        end
        MODE_SHL: begin
          reg_d    = {reg_q[WIDTH-2:0], sin};
          sout_d   = reg_q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_SHR: begin
          reg_d    = {sin, reg_q[WIDTH-1:1]};
          sout_d   = reg_q[0];
          is_shift = 1'b1;
        end
        MODE_ROL: begin
          reg_d    = {reg_q[WIDTH-2:0], reg_q[WIDTH-1]};
          sout_d   = reg_q[WIDTH-1];
          is_shift = 1'b1;
        end
        MODE_ROR: begin
          reg_d    = {reg_q[0], reg_q[WIDTH-1:1]};
          sout_d   = reg_q[0];
          is_shift = 1'b1;
        end
        MODE_CLR: begin
          reg_d = RST_VAL;
          cnt_d = '0;
        end
        MODE_ASR: begin
          reg_d    = {reg_q[WIDTH-1], reg_q[WIDTH-1:1]};
          sout_d   = reg_q[0];
          is_shift = 1'b1;
        end
      endcase
    end
    // Count saturates at WIDTH; done fires only on the step into saturation.
    if (is_shift) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      done_d = (cnt_q == CNT_LAST);
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      reg_q  <= RST_VAL;
      sout_q <= 1'b0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      reg_q  <= reg_d;
      sout_q <= sout_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign q    = reg_q;
  assign sout = sout_q;
  assign cnt  = cnt_q;
  assign done = done_q;

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed bench for univ_shift_reg (WIDTH=8, RST_VAL=0x3C) with immediate-assertion checks.
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam logic [2:0] M_HOLD = 3'b000, M_LOAD = 3'b001, M_SHL = 3'b010, M_SHR = 3'b011,
                         M_ROL  = 3'b100, M_ROR  = 3'b101, M_CLR = 3'b110, M_ASR = 3'b111;

  logic             clk = 1'b0;
  logic             clr_n;
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic [3:0]       cnt;
  logic             done;

  int n_vec = 0;
  int n_err = 0;

  univ_shift_reg #(.WIDTH(WIDTH), .RST_VAL(8'h3C)) dut (
    .clk  (clk),
    .clr_n(clr_n),
    .en   (en),
    .mode (mode),
    .d    (d),
    .sin  (sin),
    .q    (q),
    .sout (sout),
    .cnt  (cnt),
    .done (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] eq, input logic es,
                         input logic [3:0] ec, input logic ed);
    chk({tag, ".q"},    32'(q),    32'(eq));
    chk({tag, ".sout"}, 32'(sout), 32'(es));
    chk({tag, ".cnt"},  32'(cnt),  32'(ec));
    chk({tag, ".done"}, 32'(done), 32'(ed));
  endtask

  task automatic step(input logic e, input logic [2:0] m, input logic [7:0] dv, input logic s);
    en   = e;
    mode = m;
    d    = dv;
    sin  = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] v;
    logic       exp_sout;
    clr_n = 1'b0;
    en    = 1'b0;
    mode  = M_HOLD;
    d     = '0;
    sin   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all("por", 8'h3C, 1'b0, 4'd0, 1'b0);
    clr_n = 1'b1;

    // 1: async clear between edges
    step(1'b1, M_LOAD, 8'hFF, 1'b0);
    chk("t1_load.q", 32'(q), 32'h0000_00FF);
    #2;
    clr_n = 1'b0;
    #1;
    chk_all("t1_async", 8'h3C, 1'b0, 4'd0, 1'b0);
    #1;
    clr_n = 1'b1;
    // shifting after reset counts from zero
    step(1'b1, M_SHL, 8'h00, 1'b0);
    chk_all("t1_shl", 8'h78, 1'b0, 4'd1, 1'b0);

    // 2: shl / shr with serial input
    step(1'b1, M_LOAD, 8'hA5, 1'b0);
    chk("t2_load.cnt", 32'(cnt), 32'd0);
    step(1'b1, M_SHL, 8'h00, 1'b1);
    chk_all("t2_shl", 8'h4B, 1'b1, 4'd1, 1'b0);
    step(1'b1, M_SHR, 8'h00, 1'b0);
    chk_all("t2_shr", 8'h25, 1'b1, 4'd2, 1'b0);

    // 3: rotates and arithmetic shift
    step(1'b1, M_LOAD, 8'h81, 1'b0);
    step(1'b1, M_ROR, 8'h00, 1'b0);
    chk_all("t3_ror", 8'hC0, 1'b1, 4'd1, 1'b0);
    step(1'b1, M_ROL, 8'h00, 1'b0);
    chk_all("t3_rol", 8'h81, 1'b1, 4'd2, 1'b0);
    step(1'b1, M_LOAD, 8'h80, 1'b0);
    step(1'b1, M_ASR, 8'h00, 1'b1);
    chk_all("t3_asr", 8'hC0, 1'b0, 4'd1, 1'b0);

    // 4: saturating count and done pulse
    step(1'b1, M_LOAD, 8'h5A, 1'b0);
    v = 8'h5A;
    for (int i = 1; i <= 8; i++) begin
      exp_sout = v[7];
      v = {v[6:0], 1'b0};
      step(1'b1, M_SHL, 8'h00, 1'b0);
      chk_all($sformatf("t4_e%0d", i), v, exp_sout, 4'(i), (i == 8));
    end
    step(1'b0, M_SHL, 8'h00, 1'b1);
    chk_all("t4_en0", 8'h00, 1'b0, 4'd8, 1'b0);
    step(1'b1, M_SHL, 8'h00, 1'b1);
    chk_all("t4_e9", 8'h01, 1'b0, 4'd8, 1'b0);
    step(1'b1, M_LOAD, 8'h3F, 1'b0);
    chk_all("t4_reload", 8'h3F, 1'b0, 4'd0, 1'b0);

    // 5: enable gating
    step(1'b1, M_LOAD, 8'h12, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, M_LOAD, 8'h34, 1'b0);
      chk_all($sformatf("t5_en0_%0d", i), 8'h12, 1'b0, 4'd0, 1'b0);
    end
    step(1'b1, M_LOAD, 8'h34, 1'b0);
    chk("t5_en1.q", 32'(q), 32'h0000_0034);

    // 6: sync clear keeps sout, then hold
    step(1'b1, M_LOAD, 8'hF0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, M_SHR, 8'h00, 1'b0);
    chk_all("t6_shr5", 8'h07, 1'b1, 4'd5, 1'b0);
    step(1'b1, M_CLR, 8'hAA, 1'b1);
    chk_all("t6_clr", 8'h3C, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, M_HOLD, 8'hFF, 1'b1);
      chk_all($sformatf("t6_hold%0d", i), 8'h3C, 1'b1, 4'd0, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
